// File: rtl/timer_pkg.sv
// Shared FSM type, digit limits and time-word sizing for the lap timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  function automatic int time_width(input int min_digits);
    return 4 * (min_digits + 3);
  endfunction

endpackage

// File: rtl/bcd_digit_ud.sv
// One up/down BCD digit; carry flags a wrap so the next digit can ripple.
module bcd_digit_ud
  import timer_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // next digit value: clear beats load beats count; loads clamp to MAX
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (load) begin
      q_d = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      if (dir) begin
        q_d = (q_q == 4'd0) ? MAX : (q_q - 4'd1);
      end else begin
        q_d = (q_q == MAX) ? 4'd0 : (q_q + 4'd1);
      end
    end else begin
      q_d = q_q;
    end
  end

  // digit register
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = en & (dir ? (q_q == 4'd0) : (q_q == MAX));

endmodule

// File: rtl/lap_timer.sv
// Up/down BCD lap timer: prescaler, control FSM, saturating digit chain
// and lap capture with display hold.
module lap_timer
  import timer_pkg::*;
#(
  parameter int   CLK_HZ     = 100_000_000,
  parameter int   TICK_HZ    = 10,
  parameter int   MIN_DIGITS = 2,
  localparam int  TW         = time_width(MIN_DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  input  logic          lap,
  input  logic          count_down,
  input  logic          preset_load,
  input  logic [TW-1:0] preset_val,
  output logic [TW-1:0] disp_val,
  output logic [TW-1:0] live_val,
  output logic          running,
  output logic          dir,
  output logic          lap_hold,
  output logic          expired
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ND  = MIN_DIGITS + 3;
  localparam logic [TW-1:0] MAX_VAL = {{MIN_DIGITS{DIGIT_MAX}}, TENS_MAX, DIGIT_MAX, DIGIT_MAX};
  localparam logic [TW-1:0] PRE_MAX = {{MIN_DIGITS{DIGIT_MAX}}, TENS_MAX, DIGIT_MAX, 4'd8};
  localparam logic [TW-1:0] ONE_VAL = TW'(1);

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          dir_q, dir_d;
  logic          hold_q, hold_d;
  logic [TW-1:0] lap_q, lap_d;
  logic [TW-1:0] live_s;
  logic          clr_c, load_c, stop_c, start_c, lap_c;
  logic          tick_s, at_term_s, next_term_s, adv_s, load_en_s;
  logic [ND-1:0] en_s;
  logic [ND-1:0] carry_s;
  logic          unused_carry_s;

  // only the highest-priority command of a cycle is seen
  assign clr_c   = clear;
  assign load_c  = preset_load & ~clear;
  assign stop_c  = stop & ~clear & ~preset_load;
  assign start_c = start & ~clear & ~preset_load & ~stop;
  assign lap_c   = lap & ~clear & ~preset_load & ~stop & ~start;

  assign tick_s      = (state_q == RUN) && (pre_q == PW'(DIV - 1));
  assign at_term_s   = dir_q ? (live_s == '0) : (live_s == MAX_VAL);
  assign next_term_s = dir_q ? (live_s == ONE_VAL) : (live_s == PRE_MAX);
  assign adv_s       = tick_s & ~clr_c & ~stop_c & ~at_term_s;
  assign load_en_s   = load_c & ((state_q == IDLE) || (state_q == PAUSE));

  assign en_s[0] = adv_s;

  for (genvar i = 0; i < ND; i++) begin : g_digit
    localparam logic [3:0] DMAX = (i == 2) ? TENS_MAX : DIGIT_MAX;
    bcd_digit_ud #(.MAX(DMAX)) u_digit (
      .clk      (clk),
      .rst      (rst),
      .en       (en_s[i]),
      .dir      (dir_q),
      .clr      (clr_c),
      .load     (load_en_s),
      .load_val (preset_val[4*i +: 4]),
      .q        (live_s[4*i +: 4]),
      .carry    (carry_s[i])
    );
    if (i < ND - 1) begin : g_ripple
      assign en_s[i+1] = carry_s[i];
    end
  end

  // the top digit never wraps because terminal values stop the count
  assign unused_carry_s = carry_s[ND-1];

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (clr_c) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_c) begin
            state_d = (count_down && (live_s == '0)) ? EXPIRED : RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (stop_c) begin
            state_d = PAUSE;
          end else if (at_term_s || (tick_s && next_term_s)) begin
            state_d = EXPIRED;
          end else begin
            state_d = RUN;
          end
        end
        PAUSE: begin
          if (start_c) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
    end
  end

  // prescaler counts every RUN cycle so a pause keeps the partial tick
  always_comb begin
    pre_d  = pre_q;
    dir_d  = dir_q;
    hold_d = hold_q;
    lap_d  = lap_q;
    if (clr_c) begin
      pre_d  = '0;
      dir_d  = 1'b0;
      hold_d = 1'b0;
      lap_d  = '0;
    end else begin
      if ((state_q == IDLE) && start_c) begin
        pre_d = '0;
        dir_d = count_down;
      end else if (state_q == RUN) begin
        pre_d = tick_s ? '0 : (pre_q + PW'(1));
      end else begin
        pre_d = pre_q;
      end
      if (lap_c && ((state_q == RUN) || (state_q == PAUSE))) begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          hold_d = 1'b1;
          lap_d  = live_s;
        end
      end else begin
        hold_d = hold_q;
      end
    end
  end

  // state and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      dir_q   <= 1'b0;
      hold_q  <= 1'b0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      lap_q   <= lap_d;
    end
  end

  // outputs decoded purely from registers
  always_comb begin
    running  = (state_q == RUN);
    expired  = (state_q == EXPIRED);
    dir      = dir_q;
    lap_hold = hold_q;
    live_val = live_s;
    disp_val = hold_q ? lap_q : live_s;
  end

endmodule

// File: tb/tb_lap_timer.sv
// Directed bench for lap_timer with CLK_HZ=100, TICK_HZ=10, MIN_DIGITS=2.
module tb_lap_timer;

  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          rst, start, stop, clear, lap, count_down, preset_load;
  logic [TW-1:0] preset_val;
  logic [TW-1:0] disp_val, live_val;
  logic          running, dir, lap_hold, expired;
  int            checks = 0;
  int            failures = 0;

  lap_timer #(.CLK_HZ(100), .TICK_HZ(10), .MIN_DIGITS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .count_down(count_down), .preset_load(preset_load), .preset_val(preset_val),
    .disp_val(disp_val), .live_val(live_val), .running(running), .dir(dir),
    .lap_hold(lap_hold), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_live"}, live_val, 20'h00000);
    chk({tag, "_disp"}, disp_val, 20'h00000);
    chk({tag, "_run"}, {19'd0, running}, 20'd0);
    chk({tag, "_dir"}, {19'd0, dir}, 20'd0);
    chk({tag, "_hold"}, {19'd0, lap_hold}, 20'd0);
    chk({tag, "_exp"}, {19'd0, expired}, 20'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    count_down = 1'b0; preset_load = 1'b0; preset_val = 20'h00000;
    cyc(2);
    chk_idle("reset");
    rst = 1'b0;
    cyc(1);

    // count-up from zero: first tick 10 edges after the start edge
    start = 1'b1; cyc(1); start = 1'b0;
    chk("t1_running", {19'd0, running}, 20'd1);
    cyc(9);
    chk("t1_pre_tick", live_val, 20'h00000);
    cyc(1);
    chk("t1_first_tick", live_val, 20'h00001);
    cyc(5990);
    chk("t1_600_ticks", live_val, 20'h01000);
    chk("t1_disp", disp_val, 20'h01000);
    chk("t1_still_run", {19'd0, running}, 20'd1);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk_idle("t1_clear");

    // lap capture and release, lap coinciding with a tick
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1230);
    chk("t4_live_123", live_val, 20'h00123);
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("t4_hold", {19'd0, lap_hold}, 20'd1);
    chk("t4_disp_frozen", disp_val, 20'h00123);
    cyc(10);
    chk("t4_live_moves", live_val, 20'h00124);
    chk("t4_disp_still", disp_val, 20'h00123);
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("t4_release", {19'd0, lap_hold}, 20'd0);
    chk("t4_disp_live", disp_val, 20'h00124);
    cyc(7);
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("t4_tick_live", live_val, 20'h00125);
    chk("t4_pre_tick_cap", disp_val, 20'h00124);

    // pause keeps the partial tick: stop at prescaler 4, resume ticks after 5
    cyc(4);
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("t5_paused", {19'd0, running}, 20'd0);
    cyc(100);
    chk("t5_pause_hold", live_val, 20'h00125);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(4);
    chk("t5_resume_early", live_val, 20'h00125);
    cyc(1);
    chk("t5_resume_tick", live_val, 20'h00126);
    cyc(9);
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("t5_stop_on_tick", live_val, 20'h00126);
    chk("t5_stop_run", {19'd0, running}, 20'd0);
    chk("t5_disp_held", disp_val, 20'h00124);

    // preset ignored in RUN; clear beats stop and start
    start = 1'b1; cyc(1); start = 1'b0;
    chk("t6_rerun", {19'd0, running}, 20'd1);
    preset_val = 20'h00555; preset_load = 1'b1; cyc(1); preset_load = 1'b0;
    chk("t6_preset_run", live_val, 20'h00126);
    clear = 1'b1; stop = 1'b1; start = 1'b1; cyc(1);
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    chk_idle("t6_clear");

    // count-down to expiry from 00:00.3
    preset_val = 20'h00003; preset_load = 1'b1; cyc(1); preset_load = 1'b0;
    chk("t2_preset", live_val, 20'h00003);
    count_down = 1'b1; start = 1'b1; cyc(1); start = 1'b0; count_down = 1'b0;
    chk("t2_dir", {19'd0, dir}, 20'd1);
    cyc(10);
    chk("t2_down_2", live_val, 20'h00002);
    cyc(10);
    chk("t2_down_1", live_val, 20'h00001);
    cyc(9);
    chk("t2_not_expired", {19'd0, expired}, 20'd0);
    cyc(1);
    chk("t2_zero", live_val, 20'h00000);
    chk("t2_expired", {19'd0, expired}, 20'd1);
    chk("t2_stopped", {19'd0, running}, 20'd0);
    cyc(500);
    chk("t2_hold_zero", live_val, 20'h00000);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("t2_start_ignored", {19'd0, expired}, 20'd1);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk_idle("t2_clear");

    // count-down start with zero count expires at once
    count_down = 1'b1; start = 1'b1; cyc(1); start = 1'b0; count_down = 1'b0;
    chk("t2_zero_start_exp", {19'd0, expired}, 20'd1);
    chk("t2_zero_start_run", {19'd0, running}, 20'd0);
    clear = 1'b1; cyc(1); clear = 1'b0;

    // clamped preset and count-up saturation
    preset_val = 20'hAB7CF; preset_load = 1'b1; cyc(1); preset_load = 1'b0;
    chk("t3_clamp", live_val, 20'h99599);
    preset_val = 20'h99598; preset_load = 1'b1; cyc(1); preset_load = 1'b0;
    chk("t3_preset", live_val, 20'h99598);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(10);
    chk("t3_max", live_val, 20'h99599);
    chk("t3_expired", {19'd0, expired}, 20'd1);
    cyc(30);
    chk("t3_hold_max", live_val, 20'h99599);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("t3_start_ignored", {19'd0, running}, 20'd0);
    clear = 1'b1; cyc(1); clear = 1'b0;

    // synchronous reset mid-count
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(25);
    chk("t6_before_rst", live_val, 20'h00002);
    rst = 1'b1; cyc(1);
    chk_idle("t6_rst");
    rst = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
